// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters,
// optional gshare indexing and saturating statistics counters.
module branch_predictor #(
    parameter int ADDR_WIDTH   = 32,
    parameter int INDEX_BITS   = 6,
    parameter int CTR_BITS     = 2,
    parameter int HISTORY_BITS = 0
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [ADDR_WIDTH-1:0]                           lookupPc,
    output logic                                            predTaken,
    output logic [ADDR_WIDTH-1:0]                           predTarget,
    output logic [((HISTORY_BITS > 0) ? HISTORY_BITS : 1)-1:0] lookupHistory,
    input  logic                                            updateValid,
    input  logic [ADDR_WIDTH-1:0]                           updatePc,
    input  logic [((HISTORY_BITS > 0) ? HISTORY_BITS : 1)-1:0] updateHistory,
    input  logic                                            updateIsJump,
    input  logic                                            updateTaken,
    input  logic [ADDR_WIDTH-1:0]                           updateTarget,
    input  logic                                            updateMispredict,
    output logic [31:0]                                     statBranches,
    output logic [31:0]                                     statMispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int HW      = (HISTORY_BITS > 0) ? HISTORY_BITS : 1;
    localparam logic [CTR_BITS-1:0] CTR_MAX     = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] WEAK_TAKEN  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] WEAK_NTAKEN = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic                  valid_q   [ENTRIES];
    logic [TAG_W-1:0]      tag_q     [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q  [ENTRIES];
    logic                  is_jump_q [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_q     [ENTRIES];

    logic [HW-1:0]         lookup_hist;
    logic [HW-1:0]         update_hist;
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    logic [TAG_W-1:0]      lookup_tag;
    logic [TAG_W-1:0]      update_tag;
    logic                  lookup_hit;
    logic                  update_hit;
    logic [CTR_BITS-1:0]   ctr_inc;
    logic [CTR_BITS-1:0]   ctr_dec;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookupPc[1:0], updatePc[1:0]};

    // History only advances on resolved conditional branches, so it is non-speculative.
    generate
        if (HISTORY_BITS > 0) begin : g_gshare
            logic [HW-1:0] ghr_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    ghr_q <= '0;
                end else if (updateValid && !updateIsJump) begin
                    ghr_q <= (ghr_q << 1) | HW'(updateTaken);
                end
            end

            assign lookup_hist = ghr_q;
            assign update_hist = updateHistory;
        end else begin : g_bimodal
            logic unused_hist;
            assign unused_hist = ^updateHistory;
            assign lookup_hist = '0;
            assign update_hist = '0;
        end
    endgenerate

    assign lookupHistory = lookup_hist;

    assign lookup_idx = lookupPc[INDEX_BITS+1:2] ^ INDEX_BITS'(lookup_hist);
    assign update_idx = updatePc[INDEX_BITS+1:2] ^ INDEX_BITS'(update_hist);
    assign lookup_tag = lookupPc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign update_tag = updatePc[ADDR_WIDTH-1:INDEX_BITS+2];

    always_comb begin
        lookup_hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
        predTaken  = lookup_hit && (is_jump_q[lookup_idx] || ctr_q[lookup_idx][CTR_BITS-1]);
        predTarget = lookup_hit ? target_q[lookup_idx] : lookupPc + ADDR_WIDTH'(4);
    end

    always_comb begin
        update_hit = valid_q[update_idx] && (tag_q[update_idx] == update_tag);
        ctr_inc    = (ctr_q[update_idx] == CTR_MAX) ? CTR_MAX : ctr_q[update_idx] + 1'b1;
        ctr_dec    = (ctr_q[update_idx] == '0) ? '0 : ctr_q[update_idx] - 1'b1;
    end

    // A not-taken miss leaves the table alone so it never evicts a useful entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                is_jump_q[i] <= 1'b0;
                ctr_q[i]     <= WEAK_NTAKEN;
            end
        end else if (updateValid) begin
            if (update_hit) begin
                if (updateTaken) begin
                    ctr_q[update_idx]    <= ctr_inc;
                    target_q[update_idx] <= updateTarget;
                end else begin
                    ctr_q[update_idx] <= ctr_dec;
                end
                is_jump_q[update_idx] <= updateIsJump;
            end else if (updateTaken) begin
                valid_q[update_idx]   <= 1'b1;
                tag_q[update_idx]     <= update_tag;
                target_q[update_idx]  <= updateTarget;
                is_jump_q[update_idx] <= updateIsJump;
                ctr_q[update_idx]     <= WEAK_TAKEN;
            end
        end
    end

    // Statistics hold at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            statBranches    <= '0;
            statMispredicts <= '0;
        end else if (updateValid) begin
            if (statBranches != 32'hFFFF_FFFF) begin
                statBranches <= statBranches + 32'd1;
            end
            if (updateMispredict && (statMispredicts != 32'hFFFF_FFFF)) begin
                statMispredicts <= statMispredicts + 32'd1;
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the five-stage pipelined core. It sits beside the PC control logic in instruction fetch and supplies a predicted next PC each cycle. Branches and jumps resolve in instruction decode, and that stage trains the predictor. The block holds a direct-mapped branch target buffer with per-entry saturating counters, optional global history (gshare indexing), and saturating statistics counters.

## Interface

- ADDR_WIDTH, 32, PC width; PCs are word-aligned, so bits [1:0] are ignored.
- INDEX_BITS, 6, log2 of entry count (default 64 entries).
- CTR_BITS, 2, width of each saturating direction counter; must be ≥ 1.
- HISTORY_BITS, 0, global history length. 0 selects bimodal indexing. Values 1..INDEX_BITS select gshare.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- lookupPc  in  ADDR_WIDTH  PC currently being fetched.
- predTaken  out  1  1 = redirect fetch to predTarget.
- predTarget  out  ADDR_WIDTH  predicted target (valid when predTaken).
- lookupHistory  out  max(HISTORY_BITS,1)  history used for this lookup; travels down the pipe with the instruction.
- updateValid  in  1  a branch or jump resolved in decode this cycle.
- updatePc  in  ADDR_WIDTH  PC of the resolved instruction.
- updateHistory  in  max(HISTORY_BITS,1)  lookupHistory captured when that instruction was fetched.
- updateIsJump  in  1  unconditional jump (always taken).
- updateTaken  in  1  actual outcome.
- updateTarget  in  ADDR_WIDTH  actual target.
- updateMispredict  in  1  decode detected a wrong prediction for this instruction.
- statBranches  out  32  count of updates; saturates at 0xFFFF_FFFF.
- statMispredicts  out  32  count of updates with updateMispredict; saturates.

## Operation

**Indexing**
- idx(pc,h) = pc[INDEX_BITS+1:2] XOR h, where h is zero-extended to INDEX_BITS.
- For HISTORY_BITS=0, h is forced to 0 and the history register does not exist; lookupHistory reads 0.
- tag(pc) = pc[ADDR_WIDTH-1:INDEX_BITS+2].

**Entry contents:** valid, tag, target, isJump, ctr[CTR_BITS-1:0].

**Lookup (combinational from current state)**
- Entry e = table[idx(lookupPc, ghr)].
- hit = e.valid && e.tag == tag(lookupPc).
- predTaken = hit && (e.isJump || e.ctr[MSB]).
- predTarget = e.target when hit, else lookupPc+4.

**Update (on clock edge when updateValid=1)**
- Entry u = table[idx(updatePc, updateHistory)].
- Hit: if taken, ctr = min(ctr+1, 2^CTR_BITS−1) and target = updateTarget; if not taken, ctr = max(ctr−1, 0). isJump is set to updateIsJump in both cases.
- Miss and taken: allocate (overwrite) the entry with valid=1, tag, target, isJump, and ctr = 2^(CTR_BITS−1), i.e. weakly taken.
- Miss and not taken: the table is unchanged.
- ghr = {ghr[HISTORY_BITS-2:0], updateTaken}, only when updateIsJump=0 (conditional branches only). The history is non-speculative.
- statBranches increments. statMispredicts increments if updateMispredict.

**Reset**
- All valid bits cleared; all ctr = 2^(CTR_BITS−1)−1 (weakly not taken); targets and tags = 0.
- ghr = 0; both stat counters = 0.
- Consequently predTaken=0 and predTarget=lookupPc+4 in the first cycle after reset.

## Timing

- Lookup has zero latency: outputs are combinational from lookupPc and registered state.
- An update becomes visible to lookups in the cycle after the edge on which updateValid was high.
- Lookup and update to the same index in the same cycle: the lookup sees pre-update state, with no bypass.
- Reset asserted in the same cycle as updateValid: reset wins, and the update is discarded.
- Counters saturate at both ends; there is no wrap. Stat counters hold at all-ones.
- Aliasing: two PCs sharing an index evict each other on taken allocation. The tag check prevents a false hit.
- updateValid=0: no state changes, and updateHistory, updateTaken and the other update inputs are ignored.

## Test plan

- **Reset, then lookup.** Reset, then lookupPc=0x0000_0040 → predTaken=0, predTarget=0x0000_0044, stat counters 0.
- **Bimodal training.** Update pc=0x40 taken, target=0x100 → next cycle lookup 0x40 gives predTaken=1, target=0x100. Then two not-taken updates → predTaken=0; statBranches=3.
- **Saturation.** With CTR_BITS=2, send 5 taken updates to pc=0x80 → ctr=3. One not-taken update → predTaken still 1.
- **Alias and jump.** Taken update at pc=0x40, then update pc=0x140 (same index, different tag), jump, target=0x200 → lookup 0x40 misses (predTaken=0); lookup 0x140 gives predTaken=1, target=0x200.
- **Gshare (HISTORY_BITS=4).** Updates taken, taken, not-taken → lookupHistory=4'b0110. An update using history 4'b0110 at pc=0x40 trains index 0x10^0x6=0x16 only.
- **Reset mid-stream.** Assert reset with updateValid=1 and updateMispredict=1 → all entries invalid and statMispredicts=0 on the next cycle.
